// File: rtl/onchip_intc_pkg.sv
// onchip_intc_pkg: register layouts, masks, source indices and tie order for the SH7604 interrupt controller.
package onchip_intc_pkg;
  typedef enum logic [3:0] {
    SRC_DIVU, SRC_ITI, SRC_ERI, SRC_RXI, SRC_TXI,
    SRC_TEI, SRC_ICI, SRC_OCIA, SRC_OCIB, SRC_OVI
  } src_e;
  localparam int NSRC = 10;
  localparam src_e TIE_ORDER [NSRC] = '{
    SRC_DIVU, SRC_ITI, SRC_ERI, SRC_RXI, SRC_TXI,
    SRC_TEI, SRC_ICI, SRC_OCIA, SRC_OCIB, SRC_OVI
  };
  typedef enum logic [2:0] {R_IPRB, R_VCRA, R_VCRB, R_VCRC, R_VCRD, R_IPRA, R_VCRWDT} reg_e;
  localparam int NREG = 7;
  typedef struct packed {logic [3:0] divu; logic [3:0] rsv0; logic [3:0] wdt; logic [3:0] rsv1;} ipra_t;
  typedef struct packed {logic [3:0] sci; logic [3:0] frt; logic [7:0] rsv;} iprb_t;
  typedef struct packed {logic rsv0; logic [6:0] hi; logic rsv1; logic [6:0] lo;} vcr_t;
  localparam logic [31:0] REG_ADDR [NREG] = '{
    32'hFFFF_FE60, 32'hFFFF_FE62, 32'hFFFF_FE64, 32'hFFFF_FE66,
    32'hFFFF_FE68, 32'hFFFF_FEE2, 32'hFFFF_FEE4
  };
  localparam logic [15:0] REG_WMASK [NREG] = '{
    16'hFF00, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F00, 16'hF0F0, 16'h7F00
  };
  localparam logic [15:0] REG_RMASK [NREG] = REG_WMASK;
  localparam logic [15:0] REG_INIT = 16'h0000;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK} state_e;
  function automatic logic [15:0] byte_mask(input logic [1:0] ba);
    return {{8{ba[1]}}, {8{ba[0]}}};
  endfunction
endpackage

// File: rtl/onchip_intc_prio_enc.sv
// intc_prio_enc: picks the highest-level requesting source; earlier entries of TIE_ORDER win ties.
module intc_prio_enc
  import onchip_intc_pkg::*;
(
  input  logic [NSRC-1:0] i_req,
  input  logic [3:0]      i_lvl [NSRC],
  output logic [3:0]      o_lvl,
  output src_e            o_idx
);
  always_comb begin
    o_lvl = '0;
    o_idx = SRC_DIVU;
    for (int k = 0; k < NSRC; k++)
      if (i_req[TIE_ORDER[k]] && i_lvl[TIE_ORDER[k]] > o_lvl) begin
        o_lvl = i_lvl[TIE_ORDER[k]];
        o_idx = TIE_ORDER[k];
      end
  end
endmodule

// File: rtl/onchip_intc.sv
// onchip_intc: IPR/VCR register file, registered arbitration and the level/vector handshake toward the CPU.
module onchip_intc
  import onchip_intc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  input  logic        FRT_ICI_IRQ,
  input  logic        FRT_OCIA_IRQ,
  input  logic        FRT_OCIB_IRQ,
  input  logic        FRT_OVI_IRQ,
  input  logic        SCI_ERI_IRQ,
  input  logic        SCI_RXI_IRQ,
  input  logic        SCI_TXI_IRQ,
  input  logic        SCI_TEI_IRQ,
  input  logic        WDT_ITI_IRQ,
  input  logic        DIVU_OVFI_IRQ,
  input  logic [6:0]  DIVU_VEC,
  output logic [3:0]  INT_LVL,
  output logic [6:0]  INT_VEC,
  input  logic        INT_ACK
);
  logic [15:0]     r_reg [NREG];
  logic [3:0]      r_lvl;
  logic [6:0]      r_vec;
  state_e          r_st;
  logic [31:0]     r_do;
  logic [NREG-1:0] w_hit;
  logic            w_lane;
  logic            w_unused;
  logic [15:0]     w_wd;
  logic [15:0]     w_bm;
  logic [15:0]     w_rd;
  ipra_t           w_ipra;
  iprb_t           w_iprb;
  vcr_t            w_vcra, w_vcrb, w_vcrc, w_vcrd, w_vcrw;
  logic [NSRC-1:0] w_req;
  logic [3:0]      w_lvl [NSRC];
  logic [6:0]      w_vec [NSRC];
  logic [3:0]      w_win_lvl;
  logic [6:0]      w_win_vec;
  src_e            w_win_idx;
  // Byte address bit 0 does not affect register selection.
  assign w_unused  = IBUS_A[0];
  assign w_lane    = IBUS_A[1];
  assign w_wd      = w_lane ? IBUS_DI[15:0] : IBUS_DI[31:16];
  assign w_bm      = byte_mask(w_lane ? IBUS_BA[1:0] : IBUS_BA[3:2]);
  assign IBUS_ACT  = |w_hit;
  assign IBUS_BUSY = 1'b0;
  assign IBUS_DO   = r_do;
  assign INT_LVL   = r_lvl;
  assign INT_VEC   = r_vec;
  always_comb begin
    w_rd = '0;
    for (int r = 0; r < NREG; r++) begin
      w_hit[r] = IBUS_A[31:1] == REG_ADDR[r][31:1];
      w_rd |= w_hit[r] ? (r_reg[r] & REG_RMASK[r]) : '0;
    end
  end
  assign w_ipra = ipra_t'(r_reg[R_IPRA]);
  assign w_iprb = iprb_t'(r_reg[R_IPRB]);
  assign w_vcra = vcr_t'(r_reg[R_VCRA]);
  assign w_vcrb = vcr_t'(r_reg[R_VCRB]);
  assign w_vcrc = vcr_t'(r_reg[R_VCRC]);
  assign w_vcrd = vcr_t'(r_reg[R_VCRD]);
  assign w_vcrw = vcr_t'(r_reg[R_VCRWDT]);
  assign w_req = {FRT_OVI_IRQ, FRT_OCIB_IRQ, FRT_OCIA_IRQ, FRT_ICI_IRQ, SCI_TEI_IRQ,
                  SCI_TXI_IRQ, SCI_RXI_IRQ, SCI_ERI_IRQ, WDT_ITI_IRQ, DIVU_OVFI_IRQ};
  always_comb begin
    w_lvl[SRC_DIVU] = w_ipra.divu;
    w_lvl[SRC_ITI]  = w_ipra.wdt;
    w_lvl[SRC_ERI]  = w_iprb.sci;
    w_lvl[SRC_RXI]  = w_iprb.sci;
    w_lvl[SRC_TXI]  = w_iprb.sci;
    w_lvl[SRC_TEI]  = w_iprb.sci;
    w_lvl[SRC_ICI]  = w_iprb.frt;
    w_lvl[SRC_OCIA] = w_iprb.frt;
    w_lvl[SRC_OCIB] = w_iprb.frt;
    w_lvl[SRC_OVI]  = w_iprb.frt;
    w_vec[SRC_DIVU] = DIVU_VEC;
    w_vec[SRC_ITI]  = w_vcrw.hi;
    w_vec[SRC_ERI]  = w_vcra.hi;
    w_vec[SRC_RXI]  = w_vcra.lo;
    w_vec[SRC_TXI]  = w_vcrb.hi;
    w_vec[SRC_TEI]  = w_vcrb.lo;
    w_vec[SRC_ICI]  = w_vcrc.hi;
    w_vec[SRC_OCIA] = w_vcrc.lo;
    w_vec[SRC_OCIB] = w_vcrc.lo;
    w_vec[SRC_OVI]  = w_vcrd.hi;
  end
  intc_prio_enc u_enc (
    .i_req (w_req),
    .i_lvl (w_lvl),
    .o_lvl (w_win_lvl),
    .o_idx (w_win_idx)
  );
  assign w_win_vec = (w_win_lvl != '0) ? w_vec[w_win_idx] : '0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)
      for (int r = 0; r < NREG; r++) r_reg[r] <= REG_INIT;
    else if (CE_R)
      for (int r = 0; r < NREG; r++)
        if (!RES_N)
          r_reg[r] <= REG_INIT;
        else if (IBUS_REQ && IBUS_WE && w_hit[r])
          r_reg[r] <= (r_reg[r] & ~(w_bm & REG_WMASK[r])) | (w_wd & w_bm & REG_WMASK[r]);
  // Outputs only ever load from one winner at a time; ACK freezes them.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_st  <= ST_IDLE;
      r_lvl <= '0;
      r_vec <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        r_st  <= ST_IDLE;
        r_lvl <= '0;
        r_vec <= '0;
      end else
        case (r_st)
          ST_IDLE: begin
            r_lvl <= w_win_lvl;
            r_vec <= w_win_vec;
            if (w_win_lvl != '0) r_st <= ST_PEND;
          end
          ST_PEND:
            if (INT_ACK)
              r_st <= ST_ACK;
            else begin
              r_lvl <= w_win_lvl;
              r_vec <= w_win_vec;
              if (w_win_lvl == '0) r_st <= ST_IDLE;
            end
          ST_ACK:
            if (!INT_ACK) begin
              r_st  <= ST_IDLE;
              r_lvl <= '0;
              r_vec <= '0;
            end
          default: r_st <= ST_IDLE;
        endcase
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)
      r_do <= '0;
    else if (CE_F)
      r_do <= IBUS_REQ ? (w_lane ? {16'h0, w_rd} : {w_rd, 16'h0}) : '0;
endmodule

// File: tb/tb_onchip_intc.sv
// tb_onchip_intc: directed test-plan steps plus random traffic checked against a behavioural model.
module tb_onchip_intc;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b1;
  logic        CE_F = 1'b1;
  logic        RES_N = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] DI = '0;
  logic [31:0] IBUS_DO;
  logic [3:0]  BA = '0;
  logic        WE = 1'b0;
  logic        REQ = 1'b0;
  logic        IBUS_BUSY, IBUS_ACT;
  logic [9:0]  irq = '0;
  logic [6:0]  DIVU_VEC = 7'h2A;
  logic [3:0]  INT_LVL;
  logic [6:0]  INT_VEC;
  logic        INT_ACK = 1'b0;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] ADDR [7] = '{
    32'hFFFF_FE60, 32'hFFFF_FE62, 32'hFFFF_FE64, 32'hFFFF_FE66,
    32'hFFFF_FE68, 32'hFFFF_FEE2, 32'hFFFF_FEE4
  };
  localparam logic [15:0] WM [7] = '{16'hFF00, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F00, 16'hF0F0, 16'h7F00};
  localparam logic [31:0] IPRB = 32'hFFFF_FE60, VCRA = 32'hFFFF_FE62, VCRC = 32'hFFFF_FE66;
  localparam logic [31:0] VCRD = 32'hFFFF_FE68, IPRA = 32'hFFFF_FEE2, VCRW = 32'hFFFF_FEE4;
  logic [15:0] m_reg [7];
  logic [31:0] m_lvl, m_vec, m_do, m_act;
  int m_st;
  onchip_intc dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .IBUS_A(A), .IBUS_DI(DI), .IBUS_DO(IBUS_DO), .IBUS_BA(BA), .IBUS_WE(WE),
    .IBUS_REQ(REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .FRT_ICI_IRQ(irq[6]), .FRT_OCIA_IRQ(irq[7]), .FRT_OCIB_IRQ(irq[8]), .FRT_OVI_IRQ(irq[9]),
    .SCI_ERI_IRQ(irq[2]), .SCI_RXI_IRQ(irq[3]), .SCI_TXI_IRQ(irq[4]), .SCI_TEI_IRQ(irq[5]),
    .WDT_ITI_IRQ(irq[1]), .DIVU_OVFI_IRQ(irq[0]), .DIVU_VEC(DIVU_VEC),
    .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK)
  );
  always #5 CLK = ~CLK;
  // Source i: 0 DIVU, 1 ITI, 2..5 ERI/RXI/TXI/TEI, 6..9 ICI/OCIA/OCIB/OVI (also the tie order).
  function automatic logic [3:0] src_prio(input int i);
    if (i == 0) return m_reg[5][15:12];
    if (i == 1) return m_reg[5][7:4];
    if (i <= 5) return m_reg[0][15:12];
    return m_reg[0][11:8];
  endfunction
  function automatic logic [6:0] src_vec(input int i);
    case (i)
      0: return DIVU_VEC;
      1: return m_reg[6][14:8];
      2: return m_reg[1][14:8];
      3: return m_reg[1][6:0];
      4: return m_reg[2][14:8];
      5: return m_reg[2][6:0];
      6: return m_reg[3][14:8];
      7, 8: return m_reg[3][6:0];
      default: return m_reg[4][14:8];
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    logic [31:0] bl, bv;
    int lane;
    m_do = '0;
    m_act = '0;
    for (int j = 0; j < 7; j++)
      if (A[31:1] == ADDR[j][31:1]) begin
        m_act = 1;
        if (REQ) m_do = A[1] ? {16'h0, m_reg[j]} : {m_reg[j], 16'h0};
      end
    bl = 0;
    bv = 0;
    for (int i = 0; i < 10; i++)
      if (irq[i] && 32'(src_prio(i)) > bl) begin
        bl = 32'(src_prio(i));
        bv = 32'(src_vec(i));
      end
    if (!RES_N) begin
      for (int j = 0; j < 7; j++) m_reg[j] = '0;
      m_lvl = 0; m_vec = 0; m_st = 0;
    end else begin
      if (m_st == 0) begin
        m_lvl = bl; m_vec = bv;
        if (bl != 0) m_st = 1;
      end else if (m_st == 1) begin
        if (INT_ACK) m_st = 2;
        else begin
          m_lvl = bl; m_vec = bv;
          if (bl == 0) m_st = 0;
        end
      end else if (!INT_ACK) begin
        m_lvl = 0; m_vec = 0; m_st = 0;
      end
      for (int j = 0; j < 7; j++)
        if (REQ && WE && A[31:1] == ADDR[j][31:1])
          for (int b = 0; b < 2; b++) begin
            lane = A[1] ? b : b + 2;
            if (BA[lane]) m_reg[j][8*b +: 8] = DI[8*lane +: 8] & WM[j][8*b +: 8];
          end
    end
  endtask
  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    chk("int_lvl", {28'h0, INT_LVL}, m_lvl);
    chk("int_vec", {25'h0, INT_VEC}, m_vec);
    chk("ibus_do", IBUS_DO, m_do);
    chk("ibus_act", {31'h0, IBUS_ACT}, m_act);
  endtask
  task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic [3:0] ba);
    A = a;
    DI = a[1] ? {16'h5A5A, d} : {d, 16'hA5A5};
    BA = ba; REQ = 1'b1; WE = 1'b1;
    step();
    REQ = 1'b0; WE = 1'b0; BA = '0;
  endtask
  task automatic wrh(input logic [31:0] a, input logic [15:0] d);
    wr(a, d, a[1] ? 4'b0011 : 4'b1100);
  endtask
  task automatic rd(input logic [31:0] a, input logic [15:0] exp);
    A = a; REQ = 1'b1; WE = 1'b0;
    step();
    chk("rd_reg", IBUS_DO, a[1] ? {16'h0, exp} : {exp, 16'h0});
    REQ = 1'b0;
  endtask
  initial begin
    for (int j = 0; j < 7; j++) m_reg[j] = '0;
    m_lvl = 0; m_vec = 0; m_st = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_lvl", {28'h0, INT_LVL}, 32'h0);
    chk("rst_vec", {25'h0, INT_VEC}, 32'h0);
    chk("rst_do", IBUS_DO, 32'h0);
    chk("busy", {31'h0, IBUS_BUSY}, 32'h0);
    RST_N = 1'b1;
    step();
    // Single FRT source, level and shared OCI vector.
    wrh(IPRB, 16'h0500);
    wrh(VCRC, 16'h4142);
    irq[8] = 1'b1;
    step();
    chk("tp1_lvl", {28'h0, INT_LVL}, 32'd5);
    chk("tp1_vec", {25'h0, INT_VEC}, 32'h42);
    irq[8] = 1'b0;
    step();
    chk("tp1_drop", {28'h0, INT_LVL}, 32'd0);
    // Equal levels: SCI beats FRT.
    wrh(IPRB, 16'h5500);
    wrh(VCRA, 16'h3031);
    irq[3] = 1'b1; irq[6] = 1'b1;
    step();
    chk("tp2_lvl", {28'h0, INT_LVL}, 32'd5);
    chk("tp2_vec", {25'h0, INT_VEC}, 32'h31);
    irq = '0;
    step();
    // Preemption of WDT by FRT OVI.
    wrh(IPRA, 16'h0030);
    wrh(IPRB, 16'h0700);
    wrh(VCRW, 16'h5500);
    wrh(VCRD, 16'h6600);
    irq[1] = 1'b1;
    step();
    chk("tp3_lvl_a", {28'h0, INT_LVL}, 32'd3);
    chk("tp3_vec_a", {25'h0, INT_VEC}, 32'h55);
    irq[9] = 1'b1;
    step();
    chk("tp3_lvl_b", {28'h0, INT_LVL}, 32'd7);
    chk("tp3_vec_b", {25'h0, INT_VEC}, 32'h66);
    // Acknowledge freezes outputs even after all candidates vanish.
    INT_ACK = 1'b1;
    step();
    irq = '0;
    wrh(IPRB, 16'h0000);
    step();
    chk("tp4_hold_lvl", {28'h0, INT_LVL}, 32'd7);
    chk("tp4_hold_vec", {25'h0, INT_VEC}, 32'h66);
    INT_ACK = 1'b0;
    step();
    chk("tp4_rel_lvl", {28'h0, INT_LVL}, 32'd0);
    step();
    // Byte lane write, unimplemented bits, then manual reset.
    wr(IPRB, 16'hA3FF, 4'b1000);
    rd(IPRB, 16'hA300);
    wrh(VCRA, 16'hFFFF);
    rd(VCRA, 16'h7F7F);
    wrh(IPRA, 16'hFFFF);
    rd(IPRA, 16'hF0F0);
    RES_N = 1'b0;
    step();
    RES_N = 1'b1;
    for (int j = 0; j < 7; j++) rd(ADDR[j], 16'h0000);
    chk("res_lvl", {28'h0, INT_LVL}, 32'd0);
    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ 10'($urandom);
      if ($urandom_range(0, 9) == 0) INT_ACK = ~INT_ACK;
      RES_N = $urandom_range(0, 99) != 0;
      if ($urandom_range(0, 19) == 0) DIVU_VEC = 7'($urandom);
      if ($urandom_range(0, 7) != 0) A = ADDR[$urandom_range(0, 6)] | 32'($urandom_range(0, 1));
      else A = 32'hFFFF_FF00 | 32'($urandom_range(0, 31));
      DI = $urandom;
      BA = 4'($urandom);
      REQ = $urandom_range(0, 1) == 1;
      WE = $urandom_range(0, 2) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
